counter_chain_accumulator: RTL and testbench
============================================

Name: counter_chain_accumulator

Overview:
- Downstream consumer of the counter-chain compressor result word, width 2*LENGTH+3.
- Accumulates a fixed-size group of NACC compressed sums into one wide total for dot-product and multi-operand reductions.
- Inputs and outputs use valid/ready streaming. The group can be closed early by a flush.
- Sits between the registered compressor output, whose valid is pipelined alongside it, and the result sink.

Parameters:
- LENGTH, 5, column length of the upstream counter chain; input width IN_W = 2*LENGTH+3.
- NACC, 8, number of input beats per accumulation group; must be ≥ 2.
- ACC_W, IN_W+$clog2(NACC), accumulator and output width; must be ≥ IN_W.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_data  in  IN_W  unsigned compressed sum
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts a beat
- flush  in  1  close the current group after this cycle's beat, if any
- out_sum  out  ACC_W  accumulated total
- out_count  out  $clog2(NACC+1)  beats contained in out_sum
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- out_ovf  out  1  accumulator saturated (see Optional Feature)

Behaviour:
- Reset: on a clk edge with rst_n=0, the block goes to IDLE and clears acc, cnt, out_sum, out_count, out_valid and out_ovf to 0. in_ready is forced to 0 combinationally while rst_n=0. Reset mid-group discards the partial sum.
- A beat is accepted when in_valid & in_ready at a clk edge. in_data is zero-extended to ACC_W and added to acc; cnt increments.
- FSM states:
  - IDLE: acc=0, cnt=0, in_ready=1.
    - Accepted beat → ACCUM.
    - Accepted beat with flush, or NACC reached → DONE.
    - flush with no beat → ignored; stay IDLE and emit nothing.
  - ACCUM: in_ready=1.
    - Accepted beat that makes cnt==NACC → DONE.
    - flush, with or without a beat → DONE; a simultaneous beat is included.
  - DONE: out_valid=1 and in_ready=0. out_sum and out_count are stable until out_ready.
    - out_ready=1 → IDLE at that edge, clearing acc, cnt and out_ovf.
    - in_valid and flush are ignored in DONE.
- Latency: out_valid rises on the edge that accepts the closing beat or flush, so results are visible the cycle after the last accept. Minimum inter-group gap is 1 cycle (DONE→IDLE).
- No combinational path exists from in_* to out_* or from out_ready to in_ready.
- Arithmetic: unsigned throughout. With the default ACC_W no overflow is possible. With a reduced ACC_W, overflow follows Optional Feature.

Optional Feature:
- Macro: CCACC_SATURATE_EN.
- Defined:
  - Each add is checked for carry-out beyond ACC_W.
  - On carry, acc clamps to all-ones and out_ovf is set sticky for the group.
  - Later beats keep acc at all-ones.
- Undefined: acc wraps modulo 2^ACC_W and out_ovf is tied 0.

Decomposition:
- Package ccacc_pkg:
  - state typedef enum {IDLE, ACCUM, DONE}.
  - Width functions for in_w(LENGTH), acc_w(LENGTH,NACC) and cnt_w(NACC).
- Sub-module ccacc_add: combinational zero-extend adder with optional saturation and carry-out, ACC_W parameterised. It is instantiated once and isolates the macro-dependent logic.

Test Plan (LENGTH=5, NACC=8, so IN_W=13 and ACC_W=16, unless noted):
- Reset: after 3 beats, hold rst_n=0 for 2 cycles → out_valid=0, in_ready=0 during reset. A fresh group of 8×1 then gives out_sum=8, with no stale 3-beat residue.
- Full group: 8 back-to-back beats of 100 with out_ready=1 → out_valid for exactly 1 cycle, the cycle after the 8th accept, with out_sum=800, out_count=8.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 → out_valid held, out_sum=800 stable, in_ready=0, no beats consumed. Releasing out_ready → IDLE next cycle and the next beat is accepted.
- Flush:
  - Beats 1, 2, 3 with flush asserted alongside beat 3 → out_sum=6, out_count=3.
  - flush in IDLE with in_valid=0 → no out_valid.
- Maximum: 8 beats of 8191 at default ACC_W → out_sum=65528, out_ovf=0.
- Overflow with ACC_W=14 override, 8 beats of 8191:
  - With CCACC_SATURATE_EN → out_sum=16383, out_ovf=1.
  - Without → out_sum=16376, out_ovf=0.

Source files
------------

// File: rtl/ccacc_pkg.sv
// Shared state type and width helpers for the counter-chain result accumulator.
package ccacc_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } ccacc_state_e;

  // Width of one compressed sum coming out of a LENGTH-deep counter chain.
  function automatic int unsigned in_w(input int unsigned length);
    return 2 * length + 3;
  endfunction

  function automatic int unsigned acc_w(input int unsigned length, input int unsigned nacc);
    return in_w(length) + $clog2(nacc);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned nacc);
    return $clog2(nacc + 1);
  endfunction

endpackage

// File: rtl/ccacc_add.sv
// Zero-extending accumulator adder; CCACC_SATURATE_EN selects clamp-to-all-ones on carry-out,
// otherwise the sum wraps and ovf_o is tied low.
module ccacc_add #(
  parameter int unsigned IN_W  = 13,
  parameter int unsigned ACC_W = 16
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [IN_W-1:0]  data_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             ovf_o
);

`ifdef CCACC_SATURATE_EN
  logic [ACC_W:0] wide_sum;

  always_comb begin
    wide_sum = {1'b0, acc_i} + (ACC_W + 1)'(data_i);
    ovf_o    = wide_sum[ACC_W];
    sum_o    = ovf_o ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
  end
`else
  always_comb begin
    sum_o = acc_i + ACC_W'(data_i);
    ovf_o = 1'b0;
  end
`endif

endmodule

// File: rtl/counter_chain_accumulator.sv
// Groups NACC compressed sums (or fewer, on flush) into one wide total with valid/ready on both
// sides. Optional saturation is controlled by CCACC_SATURATE_EN.
module counter_chain_accumulator
  import ccacc_pkg::*;
#(
  parameter int unsigned LENGTH = 5,
  parameter int unsigned NACC   = 8,
  parameter int unsigned ACC_W  = acc_w(LENGTH, NACC)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [in_w(LENGTH)-1:0]  in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [ACC_W-1:0]         out_sum,
  output logic [cnt_w(NACC)-1:0]   out_count,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_ovf
);

  localparam int unsigned IN_W  = in_w(LENGTH);
  localparam int unsigned CNT_W = cnt_w(NACC);

  ccacc_state_e     state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             accept;
  logic [CNT_W-1:0] cnt_inc;
  logic             last_beat;

  ccacc_add #(
    .IN_W  (IN_W),
    .ACC_W (ACC_W)
  ) u_add (
    .acc_i  (acc_q),
    .data_i (in_data),
    .sum_o  (add_sum),
    .ovf_o  (add_ovf)
  );

  assign in_ready  = rst_n && (state_q != StDone);
  assign out_valid = (state_q == StDone);
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = ovf_q;

  always_comb begin
    accept      = in_valid && in_ready;
    cnt_inc     = cnt_q + CNT_W'(1);
    last_beat   = (cnt_inc == CNT_W'(NACC));
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;

    unique case (state_q)
      StIdle, StAccum: begin
        if (accept) begin
          acc_d = add_sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | add_ovf;
        end
        // A bare flush closes only a group that already holds beats.
        if ((accept && (flush || last_beat)) || (state_q == StAccum && flush)) begin
          state_d     = StDone;
          out_sum_d   = acc_d;
          out_count_d = cnt_d;
        end else if (accept) begin
          state_d = StAccum;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
    end
  end

endmodule

// File: tb/tb_counter_chain_accumulator.sv
// Bench for counter_chain_accumulator: directed steps plus random traffic against a beat-queue
// model; a second instance with ACC_W=14 covers overflow under CCACC_SATURATE_EN or wrap.
module tb_counter_chain_accumulator;

  localparam int unsigned LENGTH = 5;
  localparam int unsigned NACC   = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] in_data;
  logic        in_valid;
  logic        flush;
  logic        out_ready;

  logic        in_ready,  in_ready2;
  logic [15:0] out_sum;
  logic [13:0] out_sum2;
  logic [3:0]  out_count, out_count2;
  logic        out_valid, out_valid2;
  logic        out_ovf,   out_ovf2;

  int checks   = 0;
  int failures = 0;

  int unsigned q[$];
  logic        m_done = 1'b0;

  always #5 clk = ~clk;

  counter_chain_accumulator #(
    .LENGTH (LENGTH),
    .NACC   (NACC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ovf   (out_ovf)
  );

  counter_chain_accumulator #(
    .LENGTH (LENGTH),
    .NACC   (NACC),
    .ACC_W  (14)
  ) dut_narrow (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .flush     (flush),
    .out_sum   (out_sum2),
    .out_count (out_count2),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_ovf   (out_ovf2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint unsigned total();
    longint unsigned t = 0;
    foreach (q[i]) t += q[i];
    return t;
  endfunction

  function automatic logic [63:0] ref_sum(input int w);
    longint unsigned t  = total();
    longint unsigned mx = (64'd1 << w) - 1;
`ifdef CCACC_SATURATE_EN
    return (t > mx) ? mx : t;
`else
    return t & mx;
`endif
  endfunction

  function automatic logic ref_ovf(input int w);
`ifdef CCACC_SATURATE_EN
    return total() > ((64'd1 << w) - 1);
`else
    return 1'b0;
`endif
  endfunction

  // One clock: drive inputs, check ready before the edge, update model, check outputs after.
  task automatic cycle(input logic v, input logic [12:0] d, input logic f, input logic r);
    logic exp_rdy;
    logic acc;
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
    #2;
    exp_rdy = rst_n && !m_done;
    chk("in_ready", in_ready, exp_rdy);
    chk("in_ready_narrow", in_ready2, exp_rdy);
    acc = v && exp_rdy;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_done = 1'b0;
    end else if (m_done) begin
      if (r) begin
        m_done = 1'b0;
        q.delete();
      end
    end else if (acc) begin
      q.push_back(int'(d));
      if (f || q.size() == NACC) m_done = 1'b1;
    end else if (f && q.size() != 0) begin
      m_done = 1'b1;
    end
    #1;
    chk("out_valid", out_valid, m_done);
    chk("out_valid_narrow", out_valid2, m_done);
    if (m_done) begin
      chk("out_sum", out_sum, ref_sum(16));
      chk("out_count", out_count, q.size());
      chk("out_ovf", out_ovf, ref_ovf(16));
      chk("out_sum_narrow", out_sum2, ref_sum(14));
      chk("out_count_narrow", out_count2, q.size());
      chk("out_ovf_narrow", out_ovf2, ref_ovf(14));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    cycle(1'b1, 13'd5, 1'b0, 1'b1);
    cycle(1'b1, 13'd5, 1'b0, 1'b1);
    chk("rst_sum", out_sum, 0);
    chk("rst_count", out_count, 0);
    chk("rst_ovf", out_ovf, 0);
    rst_n = 1'b1;

    // Partial group discarded by reset
    for (int i = 0; i < 3; i++) cycle(1'b1, 13'($urandom_range(1, 8191)), 1'b0, 1'b1);
    rst_n = 1'b0;
    cycle(1'b1, 13'd9, 1'b0, 1'b1);
    cycle(1'b1, 13'd9, 1'b0, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1'b1, 13'd1, 1'b0, 1'b1);
    chk("fresh_sum8", out_sum, 8);
    cycle(1'b0, 13'd0, 1'b0, 1'b1);

    // Full group, single-cycle out_valid
    for (int i = 0; i < 8; i++) cycle(1'b1, 13'd100, 1'b0, 1'b1);
    chk("full_sum800", out_sum, 800);
    chk("full_count8", out_count, 8);
    cycle(1'b0, 13'd0, 1'b0, 1'b1);

    // Backpressure
    for (int i = 0; i < 8; i++) cycle(1'b1, 13'd100, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 13'd7, 1'b0, 1'b0);
      chk("bp_sum800", out_sum, 800);
    end
    cycle(1'b1, 13'd7, 1'b0, 1'b1);
    cycle(1'b1, 13'd7, 1'b0, 1'b1);
    cycle(1'b0, 13'd0, 1'b1, 1'b1);
    chk("bp_next_sum", out_sum, 7);
    chk("bp_next_count", out_count, 1);
    cycle(1'b0, 13'd0, 1'b0, 1'b1);

    // Flush with beat, then flush while idle
    cycle(1'b1, 13'd1, 1'b0, 1'b1);
    cycle(1'b1, 13'd2, 1'b0, 1'b1);
    cycle(1'b1, 13'd3, 1'b1, 1'b1);
    chk("flush_sum6", out_sum, 6);
    chk("flush_count3", out_count, 3);
    cycle(1'b0, 13'd0, 1'b0, 1'b1);
    cycle(1'b0, 13'd0, 1'b1, 1'b1);
    cycle(1'b0, 13'd0, 1'b0, 1'b1);

    // Maximum inputs: exact at default width, overflow on the narrow instance
    for (int i = 0; i < 8; i++) cycle(1'b1, 13'd8191, 1'b0, 1'b0);
    chk("max_sum", out_sum, 65528);
    chk("max_ovf", out_ovf, 0);
`ifdef CCACC_SATURATE_EN
    chk("narrow_sat_sum", out_sum2, 16383);
    chk("narrow_sat_ovf", out_ovf2, 1);
`else
    chk("narrow_wrap_sum", out_sum2, 16376);
    chk("narrow_wrap_ovf", out_ovf2, 0);
`endif
    cycle(1'b0, 13'd0, 1'b0, 1'b1);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      cycle($urandom_range(0, 3) != 0, 13'($urandom_range(0, 8191)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
